// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: arbitrates independent write and read request channels onto the single RW
// port of a byte-masked SRAM array, one operation per cycle. Read data returns through a small
// in-order response FIFO with valid/ready backpressure. Reads are only granted while the FIFO
// can guarantee a slot for the data, so the array's read data never needs to be stalled.
module sram_port_arbiter #(
  parameter int unsigned AddrW     = 12,
  parameter int unsigned DataW     = 80,
  parameter int unsigned MaskW     = DataW / 8,
  parameter int unsigned RespDepth = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  // Write request channel
  input  logic             w_valid_i,
  output logic             w_ready_o,
  input  logic [AddrW-1:0] w_addr_i,
  input  logic [DataW-1:0] w_data_i,
  input  logic [MaskW-1:0] w_mask_i,
  // Read request channel
  input  logic             r_valid_i,
  output logic             r_ready_o,
  input  logic [AddrW-1:0] r_addr_i,
  // Read response channel
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [DataW-1:0] resp_data_o,
  // Array RW port
  output logic             sram_en_o,
  output logic             sram_wmode_o,
  output logic [AddrW-1:0] sram_addr_o,
  output logic [MaskW-1:0] sram_wmask_o,
  output logic [DataW-1:0] sram_wdata_o,
  input  logic [DataW-1:0] sram_rdata_i
);

  localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
  localparam int unsigned CntW = $clog2(RespDepth + 1);
  // One extra bit so count + inflight never wraps before the compare.
  localparam int unsigned OccW = CntW + 1;

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(RespDepth - 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(RespDepth);
  localparam logic [OccW-1:0] DepthOcc = OccW'(RespDepth);

  // State
  logic                 prio_q, prio_d;        // 0: write wins a tie, 1: read wins a tie
  logic                 inflight_q, inflight_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [DataW-1:0]     fifo_q [RespDepth];

  // Combinational control
  logic                 w_req;
  logic                 r_elig;
  logic                 w_gnt;
  logic                 r_gnt;
  logic                 push;
  logic                 pop;
  logic [OccW-1:0]      occ;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign push = inflight_q;
  assign pop  = resp_valid_o && resp_ready_i;

  // Eligibility and arbitration; nothing is granted while reset is held.
  always_comb begin
    occ    = {1'b0, count_q} + OccW'(inflight_q) - OccW'(pop);
    w_req  = w_valid_i && !rst_i;
    r_elig = r_valid_i && !rst_i && (occ < DepthOcc);
    w_gnt  = 1'b0;
    r_gnt  = 1'b0;
    prio_d = prio_q;
    if (w_req && r_elig) begin
      w_gnt  = !prio_q;
      r_gnt  = prio_q;
      // Hand the next tie to the channel that just lost.
      prio_d = !prio_q;
    end else if (w_req) begin
      w_gnt = 1'b1;
    end else if (r_elig) begin
      r_gnt = 1'b1;
    end
  end

  // Handshakes and array port drive.
  always_comb begin
    w_ready_o    = w_gnt;
    r_ready_o    = r_gnt;
    sram_en_o    = w_gnt || r_gnt;
    sram_wmode_o = w_gnt;
    sram_addr_o  = '0;
    sram_wmask_o = '0;
    sram_wdata_o = '0;
    if (!rst_i) begin
      sram_addr_o = w_gnt ? w_addr_i : r_addr_i;
    end
    if (w_gnt) begin
      sram_wmask_o = w_mask_i;
      sram_wdata_o = w_data_i;
    end
  end

  // Response FIFO next-state: push the array data one cycle after a read issue.
  always_comb begin
    inflight_d = r_gnt;
    rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d    = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  assign resp_valid_o = (count_q != '0);
  assign resp_data_o  = fifo_q[rd_ptr_q];

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q     <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      prio_q     <= prio_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage; sram_rdata only reaches outputs through these registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RespDepth; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push) begin
      fifo_q[wr_ptr_q] <= sram_rdata_i;
    end
  end

  // A push into a full FIFO would mean the eligibility rule was broken.
  assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && (count_q == FullCnt)));

  // Only one array operation per cycle.
  assert property (@(posedge clk_i) disable iff (rst_i) !(w_gnt && r_gnt));

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural byte-masked array behind the RW port.
module tb_sram_port_arbiter;

  logic        clk;
  logic        rst;
  logic        w_valid, w_ready;
  logic [11:0] w_addr;
  logic [79:0] w_data;
  logic [9:0]  w_mask;
  logic        r_valid, r_ready;
  logic [11:0] r_addr;
  logic        resp_valid, resp_ready;
  logic [79:0] resp_data;
  logic        sram_en, sram_wmode;
  logic [11:0] sram_addr;
  logic [9:0]  sram_wmask;
  logic [79:0] sram_wdata;
  logic [79:0] sram_rdata;

  int n_checks = 0;
  int n_errors = 0;

  sram_port_arbiter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .w_valid_i    (w_valid),
    .w_ready_o    (w_ready),
    .w_addr_i     (w_addr),
    .w_data_i     (w_data),
    .w_mask_i     (w_mask),
    .r_valid_i    (r_valid),
    .r_ready_o    (r_ready),
    .r_addr_i     (r_addr),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_data_o  (resp_data),
    .sram_en_o    (sram_en),
    .sram_wmode_o (sram_wmode),
    .sram_addr_o  (sram_addr),
    .sram_wmask_o (sram_wmask),
    .sram_wdata_o (sram_wdata),
    .sram_rdata_i (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural array: masked write, registered read data.
  logic [79:0] mem [4096];
  logic [79:0] word;
  always @(posedge clk) begin
    if (sram_en && sram_wmode) begin
      word = mem[sram_addr];
      for (int b = 0; b < 10; b++) begin
        if (sram_wmask[b]) word[8*b +: 8] = sram_wdata[8*b +: 8];
      end
      mem[sram_addr] <= word;
    end
    if (sram_en && !sram_wmode) sram_rdata <= mem[sram_addr];
  end

  task automatic check_eq(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [79:0] d, input logic [9:0] m,
                    input string tag);
    w_valid = 1'b1;
    w_addr  = a;
    w_data  = d;
    w_mask  = m;
    #1;
    check_eq({tag, "_wready"}, w_ready, 1'b1);
    check_eq({tag, "_en"}, sram_en, 1'b1);
    check_eq({tag, "_wmode"}, sram_wmode, 1'b1);
    check_eq({tag, "_addr"}, sram_addr, a);
    check_eq({tag, "_wmask"}, sram_wmask, m);
    check_eq({tag, "_wdata"}, sram_wdata, d);
    step();
    w_valid = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [79:0] exp, input string tag);
    r_valid = 1'b1;
    r_addr  = a;
    #1;
    check_eq({tag, "_rready"}, r_ready, 1'b1);
    check_eq({tag, "_en"}, sram_en, 1'b1);
    check_eq({tag, "_wmode"}, sram_wmode, 1'b0);
    check_eq({tag, "_addr"}, sram_addr, a);
    check_eq({tag, "_wmask"}, sram_wmask, 10'h000);
    check_eq({tag, "_wdata"}, sram_wdata, 80'h0);
    step();
    r_valid = 1'b0;
    #1;
    check_eq({tag, "_rv_n1"}, resp_valid, 1'b0);
    step();
    check_eq({tag, "_rv_n2"}, resp_valid, 1'b1);
    check_eq({tag, "_data"}, resp_data, exp);
    step();
    check_eq({tag, "_rv_after"}, resp_valid, 1'b0);
  endtask

  logic [79:0] alt_d [3];
  logic [79:0] bp_d  [4];
  logic        wf, rf;
  int          nr, wi, ri, issued;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with requests pending: nothing may be granted or driven.
    rst        = 1'b1;
    w_valid    = 1'b1;
    r_valid    = 1'b1;
    w_addr     = 12'hABC;
    r_addr     = 12'h123;
    w_data     = 80'h5555_5555_5555_5555_5555;
    w_mask     = 10'h3FF;
    resp_ready = 1'b1;
    step();
    check_eq("rst_resp_valid", resp_valid, 1'b0);
    check_eq("rst_w_ready", w_ready, 1'b0);
    check_eq("rst_r_ready", r_ready, 1'b0);
    check_eq("rst_en", sram_en, 1'b0);
    check_eq("rst_wmode", sram_wmode, 1'b0);
    check_eq("rst_addr", sram_addr, 12'h000);
    check_eq("rst_wmask", sram_wmask, 10'h000);
    check_eq("rst_wdata", sram_wdata, 80'h0);
    w_valid = 1'b0;
    r_valid = 1'b0;
    rst     = 1'b0;
    step();

    // Full write then read-back.
    wr(12'h005, 80'h1A19_1817_1615_1413_1211, 10'h3FF, "wfull");
    rd(12'h005, 80'h1A19_1817_1615_1413_1211, "rfull");

    // Partial write touches byte 0 only.
    wr(12'h005, 80'h0000_0000_0000_0000_00FF, 10'h001, "wpart");
    rd(12'h005, 80'h1A19_1817_1615_1413_12FF, "rpart");

    // Contending channels from reset: W,R,W,R,W,R.
    rst = 1'b1;
    step();
    rst = 1'b0;
    alt_d[0] = 80'hA0A0_A0A0_A0A0_A0A0_A0A0;
    alt_d[1] = 80'hB1B1_B1B1_B1B1_B1B1_B1B1;
    alt_d[2] = 80'hC2C2_C2C2_C2C2_C2C2_C2C2;
    w_valid = 1'b1;
    r_valid = 1'b1;
    w_addr  = 12'h020;
    w_data  = alt_d[0];
    w_mask  = 10'h3FF;
    r_addr  = 12'h020;
    wi = 0;
    ri = 0;
    nr = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check_eq($sformatf("alt_w%0d", i), w_ready, (i % 2 == 0));
      check_eq($sformatf("alt_r%0d", i), r_ready, (i % 2 == 1));
      wf = w_ready;
      rf = r_ready;
      if (resp_valid) begin
        if (nr < 3) check_eq($sformatf("alt_resp%0d", nr), resp_data, alt_d[nr]);
        nr++;
      end
      step();
      if (wf) begin
        wi++;
        if (wi < 3) begin
          w_addr = 12'h020 + 12'(wi);
          w_data = alt_d[wi];
        end
      end
      if (rf) begin
        ri++;
        r_addr = 12'h020 + 12'(ri);
      end
    end
    w_valid = 1'b0;
    r_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (resp_valid) begin
        if (nr < 3) check_eq($sformatf("alt_resp%0d", nr), resp_data, alt_d[nr]);
        nr++;
      end
      step();
    end
    check_eq("alt_nresp", 80'(nr), 80'd3);

    // Backpressure: with resp_ready low only two reads are accepted.
    bp_d[0] = 80'hD0D0_0000_0000_0000_0000;
    bp_d[1] = 80'hD1D1_0000_0000_0000_0001;
    bp_d[2] = 80'hD2D2_0000_0000_0000_0002;
    bp_d[3] = 80'hD3D3_0000_0000_0000_0003;
    for (int i = 0; i < 4; i++) wr(12'(i), bp_d[i], 10'h3FF, $sformatf("bpw%0d", i));
    resp_ready = 1'b0;
    r_valid    = 1'b1;
    r_addr     = 12'h000;
    issued     = 0;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_eq($sformatf("bp_rready%0d", j), r_ready, (j < 2));
      if (j >= 2) begin
        check_eq($sformatf("bp_rv%0d", j), resp_valid, 1'b1);
        check_eq($sformatf("bp_head%0d", j), resp_data, bp_d[0]);
      end
      rf = r_ready;
      step();
      if (rf) begin
        issued++;
        r_addr = 12'(issued);
      end
    end
    resp_ready = 1'b1;
    #1;
    check_eq("bp_resume", r_ready, 1'b1);
    nr = 0;
    for (int j = 0; j < 20; j++) begin
      #1;
      rf = r_valid && r_ready;
      if (resp_valid) begin
        if (nr < 4) check_eq($sformatf("bp_resp%0d", nr), resp_data, bp_d[nr]);
        nr++;
      end
      step();
      if (rf) begin
        issued++;
        if (issued == 4) r_valid = 1'b0;
        else r_addr = 12'(issued);
      end
    end
    check_eq("bp_nresp", 80'(nr), 80'd4);
    check_eq("bp_issued", 80'(issued), 80'd4);

    // Read then write same address: read sees old data, later read sees new.
    wr(12'h010, 80'h0123_4567_89AB_CDEF_0011, 10'h3FF, "raw_init");
    r_valid = 1'b1;
    r_addr  = 12'h010;
    #1;
    check_eq("raw_rready", r_ready, 1'b1);
    step();
    r_valid = 1'b0;
    w_valid = 1'b1;
    w_addr  = 12'h010;
    w_data  = 80'hFEDC_BA98_7654_3210_EEFF;
    w_mask  = 10'h3FF;
    #1;
    check_eq("raw_wready", w_ready, 1'b1);
    step();
    w_valid = 1'b0;
    #1;
    check_eq("raw_rv", resp_valid, 1'b1);
    check_eq("raw_old", resp_data, 80'h0123_4567_89AB_CDEF_0011);
    step();
    rd(12'h010, 80'hFEDC_BA98_7654_3210_EEFF, "raw_new");

    // Reset one cycle after a read handshake discards the in-flight read.
    r_valid = 1'b1;
    r_addr  = 12'h005;
    #1;
    check_eq("mr_rready", r_ready, 1'b1);
    step();
    rst     = 1'b1;
    w_valid = 1'b1;
    r_valid = 1'b1;
    w_addr  = 12'h456;
    r_addr  = 12'h123;
    w_data  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    w_mask  = 10'h3FF;
    #1;
    check_eq("mr_resp_valid", resp_valid, 1'b0);
    check_eq("mr_w_ready", w_ready, 1'b0);
    check_eq("mr_r_ready", r_ready, 1'b0);
    check_eq("mr_en", sram_en, 1'b0);
    check_eq("mr_wmode", sram_wmode, 1'b0);
    check_eq("mr_addr", sram_addr, 12'h000);
    check_eq("mr_wmask", sram_wmask, 10'h000);
    check_eq("mr_wdata", sram_wdata, 80'h0);
    step();
    check_eq("mr_rv_held", resp_valid, 1'b0);
    step();
    rst     = 1'b0;
    w_valid = 1'b0;
    r_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq($sformatf("mr_stale%0d", i), resp_valid, 1'b0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Front-end controller for the single-port 4096x80 byte-masked data array. It accepts independent write and read request channels (valid/ready), arbitrates them onto the array's one RW port at one operation per cycle, and returns read data through a small response FIFO with backpressure. The block sits directly upstream of the array macro and drives its RW port.

## Interface
- ADDR_W, 12, array address width
- DATA_W, 80, data width; must be a multiple of 8
- MASK_W, DATA_W/8 (10), byte-enable width
- RESP_DEPTH, 2, response FIFO entries; minimum 2

- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- w_valid / w_ready  in / out  1  write request handshake
- w_addr  in  ADDR_W  write address
- w_data  in  DATA_W  write data
- w_mask  in  MASK_W  byte enables; bit i covers data[8i+7:8i]
- r_valid / r_ready  in / out  1  read request handshake
- r_addr  in  ADDR_W  read address
- resp_valid / resp_ready  out / in  1  read response handshake
- resp_data  out  DATA_W  read data, returned in request order
- sram_en  out  1  array port enable
- sram_wmode  out  1  1 = write, 0 = read
- sram_addr  out  ADDR_W  array address
- sram_wmask  out  MASK_W  array byte mask
- sram_wdata  out  DATA_W  array write data
- sram_rdata  in  DATA_W  array read data; valid the cycle after a read is issued

## Operation
- State: prio bit (0 = write preferred on tie), inflight bit (read issued last cycle), FIFO of RESP_DEPTH entries with a count and wrap-around rd/wr pointers.
- Read eligible when r_valid and count + inflight - pop < RESP_DEPTH, where pop = resp_valid && resp_ready. r_ready therefore depends combinationally on resp_ready.
- Grant, combinational:
  - only write requested: write granted;
  - only eligible read: read granted;
  - both: winner selected by prio;
  - a granted op flips prio to favour the other channel only when both were contending; otherwise prio holds.
- w_ready = write granted; r_ready = read granted. At most one handshake fires per cycle.
- sram_en = either grant. sram_wmode = write grant. sram_addr = w_addr on write grant, else r_addr. sram_wmask = w_mask and sram_wdata = w_data on write grant, else all zeros.
- inflight <= read grant. While inflight is 1, sram_rdata is pushed into the FIFO at the wr pointer on the next edge. The push never overflows, by the eligibility rule.
- resp_valid = count != 0; resp_data = FIFO[rd pointer]. Pointers wrap modulo RESP_DEPTH. Count changes by push minus pop; a simultaneous push and pop leaves count unchanged, including when count is 0 or full.
- Ordering: array ops execute in grant order. A read granted in cycle N captures data before a write granted in cycle N+1 to the same address takes effect, so it returns the old data. A write granted before a read is visible to that read.
- Reset, asserted at any time: prio=0, inflight=0, count=0, pointers=0. Any in-flight read and all buffered responses are discarded.
- While reset is high: w_ready=0, r_ready=0, sram_en=0.

## Timing
- Reset values: resp_valid=0, sram_en=0, sram_wmode=0, sram_addr=0, sram_wmask=0, sram_wdata=0.
- Write: accepted and issued in the same cycle; zero added latency.
- Read: r_valid && r_ready in cycle N, sram_en in cycle N, data captured at the end of N+1, resp_valid in N+2. Minimum latency is 2 cycles.
- Sustained read throughput is 1 per cycle with resp_ready held high, for RESP_DEPTH >= 2.
- With resp_ready low, at most RESP_DEPTH reads are outstanding (buffered plus inflight); r_ready is then 0.
- No combinational path from sram_rdata to any output other than through the FIFO register.

## Test plan
- Write 0x11..0x1A to addr 0x005 with mask 0x3FF, then read 0x005 -> resp_data = written value, resp_valid 2 cycles after the read handshake.
- Partial write mask 0x001 of 0xFF to addr 0x005 after the above, then read -> only byte 0 changes to 0xFF.
- w_valid and r_valid held high together for 6 cycles from reset -> grants alternate W,R,W,R,W,R; 3 responses returned in order.
- resp_ready=0, stream reads to 0x000..0x003 -> exactly 2 accepted, r_ready stays 0. Then resp_ready=1 -> responses for 0x000 and 0x001 first, remaining reads resume with no loss and no duplication.
- Read 0x010 in cycle N, write 0x010 := X in cycle N+1 -> response carries old data; a subsequent read returns X.
- Assert reset one cycle after a read handshake -> resp_valid stays 0 after release and no stale response appears; all outputs are at reset values during reset.
